fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder. It holds the program counter and issues in-order word requests to instruction memory over a valid/ready request channel. Returned words are buffered in a small instruction queue and presented to the decoder, tagged with their PC, on a valid/ready handshake. A single-cycle redirect from execute (branch/jump) flushes the queue and discards any stale in-flight responses.

---
 rtl/fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ==== fetch_unit: PC, in-order imem requests, instruction queue to decoder; rev 1.0 ====
// ==== Optional FETCH_PERF_EN macro adds the saturating bubble_cnt output.           ====
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] bubble_cnt
`endif
);

  localparam int          c_ptr_w  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int          c_cnt_w  = $clog2(QDEPTH + 1);
  localparam logic [31:0] c_nop    = 32'h0000_0013;
  localparam logic [c_cnt_w:0] c_credit = (c_cnt_w + 1)'(QDEPTH);

  logic [31:0]        pc_q, pc_d;
  logic [31:0]        q_data_q [QDEPTH];
  logic [31:0]        q_data_d [QDEPTH];
  logic [31:0]        q_pc_q   [QDEPTH];
  logic [31:0]        q_pc_d   [QDEPTH];
  logic [31:0]        inf_pc_q [QDEPTH];
  logic [31:0]        inf_pc_d [QDEPTH];
  logic [c_ptr_w-1:0] head_q, head_d, tail_q, tail_d;
  logic [c_ptr_w-1:0] inf_head_q, inf_head_d, inf_tail_q, inf_tail_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic [c_cnt_w-1:0] outstanding_q, outstanding_d;
  logic [c_cnt_w-1:0] drop_q, drop_d;

  logic               w_req_fire;
  logic               w_pop;
  logic               w_rsp_keep;
  logic [c_cnt_w:0]   w_used;
  logic [c_cnt_w-1:0] w_req_inc, w_rsp_dec, w_keep_inc, w_pop_dec;

  // Credit covers both queued words and in-flight requests, so the queue cannot overflow.
  assign w_used         = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req_valid = rst_n && !redirect && (w_used < c_credit);
  assign imem_req_addr  = pc_q;

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? q_data_q[head_q] : c_nop;
  assign instr_pc    = instr_valid ? q_pc_q[head_q]   : 32'h0000_0000;

  assign w_req_fire = imem_req_valid && imem_req_ready;
  assign w_pop      = instr_valid && instr_ready;
  assign w_rsp_keep = imem_rsp_valid && (drop_q == '0);

  assign w_req_inc  = {{(c_cnt_w-1){1'b0}}, w_req_fire};
  assign w_rsp_dec  = {{(c_cnt_w-1){1'b0}}, imem_rsp_valid};
  assign w_keep_inc = {{(c_cnt_w-1){1'b0}}, w_rsp_keep};
  assign w_pop_dec  = {{(c_cnt_w-1){1'b0}}, w_pop};

  always_comb begin
    pc_d          = pc_q;
    q_data_d      = q_data_q;
    q_pc_d        = q_pc_q;
    inf_pc_d      = inf_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    inf_head_d    = inf_head_q;
    inf_tail_d    = inf_tail_q;
    count_d       = count_q;
    drop_d        = drop_q;
    outstanding_d = outstanding_q + w_req_inc - w_rsp_dec;

    if (w_req_fire) begin
      inf_pc_d[inf_tail_q] = pc_q;
      inf_tail_d           = inf_tail_q + 1'b1;
      pc_d                 = pc_q + 32'd4;
    end
    if (imem_rsp_valid) begin
      inf_head_d = inf_head_q + 1'b1;
    end

    if (redirect) begin
      // Every request still outstanding after this edge belongs to the old stream.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = redirect_pc & ~32'h0000_0003;
      drop_d  = outstanding_d;
    end else begin
      if (w_rsp_keep) begin
        q_data_d[tail_q] = imem_rsp_data;
        q_pc_d[tail_q]   = inf_pc_q[inf_head_q];
        tail_d           = tail_q + 1'b1;
      end else if (imem_rsp_valid) begin
        drop_d = drop_q - 1'b1;
      end
      if (w_pop) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + w_keep_inc - w_pop_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      inf_head_q    <= '0;
      inf_tail_q    <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_data_q[i] <= '0;
        q_pc_q[i]   <= '0;
        inf_pc_q[i] <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      inf_head_q    <= inf_head_d;
      inf_tail_q    <= inf_tail_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      q_data_q      <= q_data_d;
      q_pc_q        <= q_pc_d;
      inf_pc_q      <= inf_pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Counts decoder-starved cycles; redirect does not touch it.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (instr_ready && !instr_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ==== tb_fetch_unit: randomized fetch_unit bench against a stream-level reference model; rev 1.0 ====
`default_nettype none

module tb_fetch_unit;

  localparam int          QDEPTH   = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready)
`ifdef FETCH_PERF_EN
    ,
    .bubble_cnt     (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: stream of fetched addresses, memory requests tagged with an epoch.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          it;
  } pend_t;

  pend_t       pending[$];
  int          live;
  int          epoch;
  int          it;
  int          rel_it;
  int          first_valid_it;
  logic [31:0] exp_req_pc;
  logic [31:0] exp_out_pc;
  logic [31:0] exp_bubbles;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          redir_pct = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit roll(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (iter %0d)", tag, got, exp, it);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect       = 1'b0;
    instr_ready    = 1'b0;
    pending.delete();
    live           = 0;
    epoch          = 0;
    rel_it         = 0;
    first_valid_it = -1;
    exp_req_pc     = RESET_PC;
    exp_out_pc     = RESET_PC;
    exp_bubbles    = '0;
    #1;
    check_eq("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check_eq("rst_req_addr", imem_req_addr, RESET_PC);
    check_eq("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instr", instr, NOP);
    check_eq("rst_instr_pc", instr_pc, 32'd0);
`ifdef FETCH_PERF_EN
    check_eq("rst_bubble_cnt", bubble_cnt, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One cycle: drive inputs after the falling edge, then check and advance the model.
  task automatic step(input int rdy_pct, input int rsp_pct, input int ir_pct,
                      input bit force_redir, input logic [31:0] force_pc);
    bit          exp_valid;
    bit          exp_rv;
    bit          rsp;
    bit          add_live;
    pend_t       e;
    logic [31:0] rpc;

    if (rel_it > 0) @(negedge clk);
    imem_req_ready = roll(rdy_pct);
    rsp = (pending.size() > 0) && (pending[0].it < it) && roll(rsp_pct);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(pending[0].addr) : $urandom;
    instr_ready    = roll(ir_pct);
    rpc = $urandom;
    if (roll(20)) rpc = 32'hFFFF_FFF0 | {28'd0, rpc[3:0]};
    redirect    = force_redir || roll(redir_pct);
    redirect_pc = force_redir ? force_pc : rpc;
    #1;

    exp_valid = (live > 0);
    exp_rv    = !redirect && (live + pending.size() < QDEPTH);
    if (first_valid_it < 0 && instr_valid) first_valid_it = rel_it;
    check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
    check_eq("instr_pc", instr_pc, exp_valid ? exp_out_pc : 32'd0);
    check_eq("instr", instr, exp_valid ? mem_word(exp_out_pc) : NOP);
    check_eq("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
    check_eq("req_addr", imem_req_addr, exp_req_pc);

    add_live = 1'b0;
    if (rsp) begin
      e = pending.pop_front();
      add_live = (e.epoch == epoch);
    end
    if (instr_ready && !exp_valid && exp_bubbles != 32'hFFFF_FFFF) exp_bubbles++;
    if (exp_valid && instr_ready) begin
      live--;
      exp_out_pc += 32'd4;
    end
    if (exp_rv && imem_req_ready) begin
      pending.push_back('{addr: exp_req_pc, epoch: epoch, it: it});
      exp_req_pc += 32'd4;
    end
    if (redirect) begin
      live       = 0;
      epoch++;
      exp_req_pc = redirect_pc & ~32'h3;
      exp_out_pc = redirect_pc & ~32'h3;
    end else if (add_live) begin
      live++;
    end
    it++;
    rel_it++;
  endtask

  initial begin
    it = 0;
    do_reset();

    // Streaming from reset with a fast memory and an always-ready decoder.
    for (int i = 0; i < 12; i++) step(100, 100, 100, 1'b0, '0);
    check_eq("first_valid_cycle", first_valid_it, 32'd2);

    // Decoder stall, then release.
    for (int i = 0; i < 6; i++) step(100, 100, 0, 1'b0, '0);
    for (int i = 0; i < 6; i++) step(100, 100, 100, 1'b0, '0);

    // Two requests in flight, then redirect to an unaligned target.
    step(100, 100, 100, 1'b1, 32'h0000_0040);
    for (int i = 0; i < 2; i++) step(100, 0, 0, 1'b0, '0);
    check_eq("inflight_before_redirect", pending.size(), 32'd2);
    step(0, 0, 0, 1'b1, 32'h0000_0103);
    for (int i = 0; i < 10; i++) step(100, 100, 100, 1'b0, '0);

    // Redirect together with a response and a pop.
    for (int i = 0; i < 3; i++) step(100, 100, 0, 1'b0, '0);
    step(100, 100, 0, 1'b0, '0);
    step(100, 100, 100, 1'b1, 32'h0000_0200);
    for (int i = 0; i < 8; i++) step(100, 100, 100, 1'b0, '0);

    // Address wrap past the top of memory.
    step(100, 100, 100, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 8; i++) step(100, 100, 100, 1'b0, '0);

    // Reset in the middle of traffic, then long randomized run.
    for (int i = 0; i < 3; i++) step(100, 50, 50, 1'b0, '0);
    do_reset();
    redir_pct = 3;
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(30, 100), $urandom_range(20, 100), $urandom_range(0, 100), 1'b0, '0);
    end
    redir_pct = 0;

`ifdef FETCH_PERF_EN
    @(negedge clk);
    check_eq("bubble_cnt", bubble_cnt, exp_bubbles);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
